// File: rtl/ring_osc_sched_pkg.sv
// Shared types and constants for the ring-oscillator timer scheduler.
package ring_osc_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StMeasure,
        StSettle,
        StReport
    } state_e;

    localparam int unsigned TMR_OUT_W      = 8;
    localparam int unsigned FINE_W         = 6;
    localparam int unsigned SAVED_BIT      = 7;
    localparam int unsigned STROBE_BIT_IDX = 6;

endpackage

// File: rtl/ring_osc_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module ring_osc_rr_arb #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic                     i_update,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gnt_idx,
    output logic                     o_gnt_valid
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan from the farthest offset down so the nearest requester is the last one kept.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % int'(N_REQ));
            if (i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_update && w_found) begin
            r_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_gnt       = w_found ? (N_REQ'(1) << w_idx) : '0;
    assign o_gnt_idx   = w_idx;
    assign o_gnt_valid = w_found;

endmodule

// File: rtl/ring_osc_sched.sv
// Shares one ring-oscillator edge timer among N_REQ channels: arbitrate, arm, measure,
// settle, and report {coarse, fine} through a valid/ready handshake.
module ring_osc_sched
    import ring_osc_sched_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned ARM_CYCLES    = 4,
    parameter int unsigned COARSE_W      = 10,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         chan_sig,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] tmr_sel,
    output logic                     tmr_slow_clk,
    output logic                     tmr_enable,
    input  logic [TMR_OUT_W-1:0]     tmr_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [COARSE_W-1:0]      res_coarse,
    output logic [FINE_W-1:0]        res_fine,
    output logic                     res_timeout
);

    localparam int unsigned SEL_W   = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [COARSE_W-1:0] COARSE_LIMIT = '1;

    state_e               r_state, w_state_nxt;
    logic [N_REQ-1:0]     r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]     r_sel, w_sel_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [COARSE_W-1:0]  r_coarse, w_coarse_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic [FINE_W-1:0]    r_fine, w_fine_nxt;

    logic                 r_sig_meta, r_sig_sync;
    logic [TMR_OUT_W-1:0] r_tmr_meta, r_tmr_sync;

    logic [N_REQ-1:0]     w_arb_gnt;
    logic [SEL_W-1:0]     w_arb_idx;
    logic                 w_arb_valid;
    logic                 w_arb_update;
    logic                 w_edge;
    logic                 w_slow_clk, w_enable, w_valid;

    ring_osc_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_update    (w_arb_update),
        .o_gnt       (w_arb_gnt),
        .o_gnt_idx   (w_arb_idx),
        .o_gnt_valid (w_arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_meta <= 1'b0;
            r_sig_sync <= 1'b0;
            r_tmr_meta <= '0;
            r_tmr_sync <= '0;
        end else begin
            r_sig_meta <= chan_sig[r_sel];
            r_sig_sync <= r_sig_meta;
            r_tmr_meta <= tmr_out;
            r_tmr_sync <= r_tmr_meta;
        end
    end

    assign w_edge = r_sig_sync != r_tmr_sync[SAVED_BIT];

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_coarse_nxt  = r_coarse;
        w_timeout_nxt = r_timeout;
        w_fine_nxt    = r_fine;
        w_arb_update  = 1'b0;
        w_slow_clk    = 1'b0;
        w_enable      = 1'b0;
        w_valid       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_arb_valid) begin
                    w_arb_update = 1'b1;
                    w_gnt_nxt    = w_arb_gnt;
                    w_sel_nxt    = w_arb_idx;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = StArm;
                end
            end
            StArm: begin
                w_enable     = 1'b1;
                w_coarse_nxt = '0;
                if (r_cnt == CNT_W'(ARM_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StMeasure;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StMeasure: begin
                w_slow_clk = 1'b1;
                w_enable   = 1'b1;
                // An edge on the limit cycle still counts as a real measurement.
                if (w_edge) begin
                    w_timeout_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = StSettle;
                end else if (r_tmr_sync[STROBE_BIT_IDX] || (r_coarse == COARSE_LIMIT)) begin
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = StSettle;
                end else begin
                    w_coarse_nxt = r_coarse + 1'b1;
                end
            end
            StSettle: begin
                w_slow_clk = 1'b1;
                w_enable   = !r_timeout;
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_fine_nxt  = r_tmr_sync[FINE_W-1:0];
                    w_state_nxt = StReport;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StReport: begin
                w_valid = 1'b1;
                if (res_ready) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_coarse  <= '0;
            r_timeout <= 1'b0;
            r_fine    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_coarse  <= w_coarse_nxt;
            r_timeout <= w_timeout_nxt;
            r_fine    <= w_fine_nxt;
        end
    end

    // Timer controls decode straight from state so reset forces the latch phase at once.
    assign gnt          = r_gnt;
    assign tmr_sel      = r_sel;
    assign tmr_slow_clk = w_slow_clk;
    assign tmr_enable   = w_enable;
    assign res_valid    = w_valid;
    assign res_id       = r_sel;
    assign res_coarse   = r_coarse;
    assign res_fine     = r_fine;
    assign res_timeout  = r_timeout;

endmodule

// File: tb/tb_ring_osc_sched.sv
// Directed bench for ring_osc_sched with a behavioural timer (saved-signal latch, strobe, fine).
module tb_ring_osc_sched;

    localparam int unsigned N_REQ         = 4;
    localparam int unsigned ARM_CYCLES    = 4;
    localparam int unsigned COARSE_W      = 6;
    localparam int unsigned SETTLE_CYCLES = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    chan_sig;
    logic [N_REQ-1:0]    gnt;
    logic [1:0]          tmr_sel;
    logic                tmr_slow_clk;
    logic                tmr_enable;
    logic [7:0]          tmr_out;
    logic                res_valid;
    logic                res_ready;
    logic [1:0]          res_id;
    logic [COARSE_W-1:0] res_coarse;
    logic [5:0]          res_fine;
    logic                res_timeout;

    logic       r_saved = 1'b0;
    logic       tb_strobe;
    logic [5:0] tb_fine;

    int n_pass = 0;
    int n_total = 0;

    ring_osc_sched #(
        .N_REQ         (N_REQ),
        .ARM_CYCLES    (ARM_CYCLES),
        .COARSE_W      (COARSE_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .chan_sig     (chan_sig),
        .gnt          (gnt),
        .tmr_sel      (tmr_sel),
        .tmr_slow_clk (tmr_slow_clk),
        .tmr_enable   (tmr_enable),
        .tmr_out      (tmr_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_coarse   (res_coarse),
        .res_fine     (res_fine),
        .res_timeout  (res_timeout)
    );

    always #5 clk = ~clk;

    // Timer model: the selected signal is latched while slow_clk is low.
    always @(posedge clk) begin
        if (!tmr_slow_clk) r_saved <= chan_sig[tmr_sel];
    end
    assign tmr_out = {r_saved, tb_strobe, tb_fine};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Runs one measurement from grant to result; toggle_at/strobe_at count MEASURE cycles.
    task automatic run_meas(input int id, input int toggle_at, input int strobe_at,
                            input int exp_coarse, input int exp_to);
        int n;
        int m;
        int off;
        logic [3:0] eg;
        eg = 4'b0001 << id;
        n = 0;
        while (gnt === 4'b0 && n < 200) begin
            step();
            n++;
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("tmr_sel", 32'(tmr_sel), id);
        n = 0;
        while (tmr_slow_clk === 1'b0 && n < 50) begin
            n++;
            step();
        end
        chk("arm_len", n, ARM_CYCLES);
        m = 0;
        off = 0;
        while (res_valid !== 1'b1 && m < 300) begin
            if (m == toggle_at) chan_sig[id] = ~chan_sig[id];
            if (m == strobe_at) tb_strobe = 1'b1;
            if (tmr_slow_clk === 1'b1 && tmr_enable === 1'b0) off++;
            step();
            m++;
        end
        tb_strobe = 1'b0;
        chk("res_valid", 32'(res_valid), 1);
        chk("res_id", 32'(res_id), id);
        chk("res_coarse", 32'(res_coarse), exp_coarse);
        chk("res_timeout", 32'(res_timeout), exp_to);
        chk("res_fine", 32'(res_fine), 32'(tb_fine));
        chk("settle_en_off", off, (exp_to != 0) ? SETTLE_CYCLES : 0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic seen;
        int n;
        rst_n     = 1'b0;
        req       = 4'b1111;
        chan_sig  = '0;
        res_ready = 1'b0;
        tb_strobe = 1'b0;
        tb_fine   = '0;
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_slow_clk", 32'(tmr_slow_clk), 0);
        chk("rst_enable", 32'(tmr_enable), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_coarse", 32'(res_coarse), 0);
        chk("rst_fine", 32'(res_fine), 0);
        chk("rst_timeout", 32'(res_timeout), 0);

        rst_n = 1'b1;
        step();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_sel", 32'(tmr_sel), 0);

        // All channels requesting, static signals: every measurement times out at the limit.
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tb_fine = 6'(5 + i * 7);
            run_meas(order[i], -1, -1, 63, 1);
            if (i == 4) req = 4'b0100;
            step();
        end

        // Edge on channel 2 at MEASURE cycle 37, seen two cycles later through the synchronizer.
        res_ready = 1'b0;
        tb_fine   = 6'h2a;
        run_meas(2, 37, -1, 39, 0);
        req = 4'b1011;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold", 32'({res_valid, gnt, res_id, res_coarse, res_timeout, res_fine}),
                32'({1'b1, 4'b0100, 2'd2, 6'd39, 1'b0, 6'h2a}));
        end
        res_ready = 1'b1;
        step();
        chk("accept_valid", 32'(res_valid), 0);
        chk("accept_gnt", 32'(gnt), 0);

        // Edge arriving on the limit cycle wins over timeout.
        tb_fine = 6'h11;
        run_meas(3, 61, -1, 63, 0);
        step();

        // Strobe forces the timeout path early.
        tb_fine = 6'h3c;
        run_meas(0, -1, 10, 12, 1);
        step();

        // Abort mid-MEASURE on channel 1.
        n = 0;
        while (tmr_slow_clk !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("abort_gnt_pre", 32'(gnt), 32'h2);
        repeat (5) step();
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("abort_slow_clk", 32'(tmr_slow_clk), 0);
        chk("abort_enable", 32'(tmr_enable), 0);
        chk("abort_gnt", 32'(gnt), 0);
        repeat (2) step();
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (100) begin
            step();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
